// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU control sequencer: accepts one instruction per handshake and steps it
// through operand fetch, execute and write-back, driving reg-file/latch/ALU strobes.
module alu_op_sequencer #(
  parameter int MULDIV_CYCLES = 4,
  parameter int SEL_W         = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [4:0]       opcode,
  input  logic [SEL_W-1:0] ra,
  input  logic [SEL_W-1:0] rb,
  input  logic [SEL_W-1:0] rc,
  output logic [SEL_W-1:0] reg_sel,
  output logic             rout,
  output logic             a_en,
  output logic             b_en,
  output logic [4:0]       alu_ctrl,
  output logic             alu_en,
  output logic             zout,
  output logic             rin,
  output logic             done,
  output logic             illegal
);

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_EXEC,
    S_WB,
    S_ERR
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_op;
  logic [SEL_W-1:0] r_ra;
  logic [SEL_W-1:0] r_rb;
  logic [SEL_W-1:0] r_rc;

  state_t           w_nextState;
  logic [CNT_W-1:0] w_nextCnt;
  logic [CNT_W-1:0] w_execLoad;
  logic [4:0]       w_nextOp;
  logic [SEL_W-1:0] w_nextRa;
  logic [SEL_W-1:0] w_nextRb;
  logic [SEL_W-1:0] w_nextRc;

  function automatic logic isUnary(input logic [4:0] op);
    return (op >= 5'd4 && op <= 5'd7) || op == 5'd10 || op == 5'd11;
  endfunction

  function automatic logic isMulDiv(input logic [4:0] op);
    return op == 5'd2 || op == 5'd3;
  endfunction

  function automatic logic isLegal(input logic [4:0] op);
    return op <= 5'd11;
  endfunction

  assign w_execLoad = isMulDiv(r_op) ? CNT_W'(MULDIV_CYCLES - 1) : '0;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextOp    = r_op;
    w_nextRa    = r_ra;
    w_nextRb    = r_rb;
    w_nextRc    = r_rc;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_nextOp    = opcode;
          w_nextRa    = ra;
          w_nextRb    = rb;
          w_nextRc    = rc;
          w_nextState = isLegal(opcode) ? S_FETCH_A : S_ERR;
        end
      end
      S_FETCH_A: begin
        w_nextState = isUnary(r_op) ? S_EXEC : S_FETCH_B;
        w_nextCnt   = w_execLoad;
      end
      S_FETCH_B: begin
        w_nextState = S_EXEC;
        w_nextCnt   = w_execLoad;
      end
      S_EXEC: begin
        if (r_cnt == '0) w_nextState = S_WB;
        else             w_nextCnt   = r_cnt - CNT_W'(1);
      end
      S_WB:    w_nextState = S_IDLE;
      S_ERR:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe is a flop output.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_rc        <= '0;
      instr_ready <= 1'b1;
      reg_sel     <= '0;
      rout        <= 1'b0;
      a_en        <= 1'b0;
      b_en        <= 1'b0;
      alu_ctrl    <= '0;
      alu_en      <= 1'b0;
      zout        <= 1'b0;
      rin         <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_op        <= w_nextOp;
      r_ra        <= w_nextRa;
      r_rb        <= w_nextRb;
      r_rc        <= w_nextRc;
      instr_ready <= 1'b0;
      reg_sel     <= '0;
      rout        <= 1'b0;
      a_en        <= 1'b0;
      b_en        <= 1'b0;
      alu_ctrl    <= '0;
      alu_en      <= 1'b0;
      zout        <= 1'b0;
      rin         <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      case (w_nextState)
        S_IDLE: instr_ready <= 1'b1;
        S_FETCH_A: begin
          reg_sel  <= w_nextRa;
          rout     <= 1'b1;
          a_en     <= 1'b1;
          alu_ctrl <= w_nextOp;
        end
        S_FETCH_B: begin
          reg_sel  <= w_nextRb;
          rout     <= 1'b1;
          b_en     <= 1'b1;
          alu_ctrl <= w_nextOp;
        end
        S_EXEC: begin
          alu_ctrl <= w_nextOp;
          alu_en   <= (w_nextCnt == '0);
        end
        S_WB: begin
          reg_sel  <= w_nextRc;
          zout     <= 1'b1;
          rin      <= 1'b1;
          done     <= 1'b1;
          alu_ctrl <= w_nextOp;
        end
        S_ERR: begin
          done    <= 1'b1;
          illegal <= 1'b1;
        end
        default: instr_ready <= 1'b0;
      endcase
    end
  end

endmodule
